intr_dispatch: RTL and testbench

//  Downstream of the interrupt manager. Consumes its 8-bit in-service vector,

---
 rtl/intr_dispatch.sv | 147 ++++++++++++++
 tb/tb_intr_dispatch.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_dispatch.sv
// Interrupt dispatcher: pushes the interrupted PC on a small return stack, redirects
// to a per-line vector, and restores the PC on return-from-interrupt.
module intr_dispatch #(
    parameter int                   PC_WIDTH   = 10,
    parameter int                   DEPTH      = 4,
    parameter logic [PC_WIDTH-1:0]  VEC_BASE   = 10'h3C0,
    parameter int                   VEC_STRIDE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          intr_active,
    input  logic [PC_WIDTH-1:0] pc_current,
    input  logic                s_return_intr,
    output logic                s_intr_jump,
    output logic                s_intr_ret,
    output logic [PC_WIDTH-1:0] pc_target,
    output logic [2:0]          intr_level,
    output logic                s_stack_full,
    output logic                s_err_overflow,
    output logic                s_err_underflow
);

    // state | meaning
    // IDLE  | waiting for an eligible request or a RETI
    // SAVE  | push return PC and line, mark line in service
    // JUMP  | one-cycle pulse, pc_target = line vector
    // RET   | one-cycle pulse, pc_target = popped return PC
    typedef enum logic [1:0] {ST_IDLE, ST_SAVE, ST_JUMP, ST_RET} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [2:0]          r_level;
    logic [2:0]          r_cand;
    logic [7:0]          r_in_service;
    logic [PC_WIDTH-1:0] r_stack_pc [DEPTH];
    logic [2:0]          r_stack_ln [DEPTH];
    logic                r_err_ovf;
    logic                r_err_udf;

    logic [7:0]          w_pending;
    logic                w_any;
    logic [2:0]          w_cand;
    logic [2:0]          w_top_ln;
    logic [PC_WIDTH-1:0] w_pop_pc;
    logic [PC_WIDTH-1:0] w_vec;
    logic                w_full;
    logic                w_eligible;
    logic                w_do_ret;
    logic                w_set_ovf;
    logic                w_set_udf;

    always_comb begin
        w_pending = intr_active & ~r_in_service;
        w_any     = |w_pending;
        w_cand    = '0;
        for (int i = 7; i >= 0; i--) begin
            if (w_pending[i]) w_cand = 3'(i);
        end
    end

    // RET is entered with r_level already decremented, so the popped entry sits at r_level.
    always_comb begin
        w_top_ln = '0;
        w_pop_pc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_level == 3'(i + 1)) w_top_ln = r_stack_ln[i];
            if (r_level == 3'(i))     w_pop_pc = r_stack_pc[i];
        end
    end

    assign w_full     = (r_level == 3'(DEPTH));
    assign w_eligible = (r_level == 3'd0) || (w_cand < w_top_ln);
    assign w_vec      = VEC_BASE + PC_WIDTH'(r_cand) * PC_WIDTH'(VEC_STRIDE);

    always_comb begin
        w_next    = r_state;
        w_do_ret  = 1'b0;
        w_set_ovf = 1'b0;
        w_set_udf = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (s_return_intr) begin
                    if (r_level != 3'd0) begin
                        w_next   = ST_RET;
                        w_do_ret = 1'b1;
                    end else begin
                        w_set_udf = 1'b1;
                    end
                end else if (w_any && w_eligible) begin
                    if (w_full) w_set_ovf = 1'b1;
                    else        w_next    = ST_SAVE;
                end
            end
            ST_SAVE: w_next = ST_JUMP;
            ST_JUMP: w_next = ST_IDLE;
            ST_RET:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_level      <= '0;
            r_cand       <= '0;
            r_in_service <= '0;
            r_err_ovf    <= 1'b0;
            r_err_udf    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack_pc[i] <= '0;
                r_stack_ln[i] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE) r_cand <= w_cand;
            if (w_set_ovf) r_err_ovf <= 1'b1;
            if (w_set_udf) r_err_udf <= 1'b1;
            if (r_state == ST_SAVE) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (r_level == 3'(i)) begin
                        r_stack_pc[i] <= pc_current;
                        r_stack_ln[i] <= r_cand;
                    end
                end
                r_in_service[r_cand] <= 1'b1;
                r_level              <= r_level + 3'd1;
            end
            if (w_do_ret) begin
                r_in_service[w_top_ln] <= 1'b0;
                r_level                <= r_level - 3'd1;
            end
        end
    end

    always_comb begin
        s_intr_jump     = (r_state == ST_JUMP);
        s_intr_ret      = (r_state == ST_RET);
        pc_target       = '0;
        if (r_state == ST_JUMP)     pc_target = w_vec;
        else if (r_state == ST_RET) pc_target = w_pop_pc;
        intr_level      = r_level;
        s_stack_full    = w_full;
        s_err_overflow  = r_err_ovf;
        s_err_underflow = r_err_udf;
    end

endmodule

// File: tb/tb_intr_dispatch.sv
// Bench for intr_dispatch: directed scenarios plus random traffic, every cycle compared
// against a return-stack reference model kept as queues.
module tb_intr_dispatch;
    localparam int              PW    = 10;
    localparam int              DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    intr_active = '0;
    logic [PW-1:0] pc_current = '0;
    logic          s_return_intr = 1'b0;
    logic          s_intr_jump, s_intr_ret, s_stack_full, s_err_overflow, s_err_underflow;
    logic [PW-1:0] pc_target;
    logic [2:0]    intr_level;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    intr_dispatch dut (
        .clk            (clk),
        .reset          (reset),
        .intr_active    (intr_active),
        .pc_current     (pc_current),
        .s_return_intr  (s_return_intr),
        .s_intr_jump    (s_intr_jump),
        .s_intr_ret     (s_intr_ret),
        .pc_target      (pc_target),
        .intr_level     (intr_level),
        .s_stack_full   (s_stack_full),
        .s_err_overflow (s_err_overflow),
        .s_err_underflow(s_err_underflow)
    );

    // reference model: return stack as two queues, in-service set derived from its contents
    logic [PW-1:0] stk_pc[$];
    logic [2:0]    stk_ln[$];
    logic          m_push;
    logic [2:0]    m_cand;
    int            m_wait;
    logic          e_jump, e_ret, e_full, e_ovf, e_udf;
    logic [PW-1:0] e_target;
    logic [2:0]    e_level;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        stk_pc.delete();
        stk_ln.delete();
        m_push = 1'b0; m_cand = '0; m_wait = 0;
        e_jump = 1'b0; e_ret = 1'b0; e_target = '0;
        e_level = '0; e_full = 1'b0; e_ovf = 1'b0; e_udf = 1'b0;
    endtask

    function automatic logic [7:0] stacked_mask();
        logic [7:0] m = '0;
        foreach (stk_ln[k]) m[stk_ln[k]] = 1'b1;
        return m;
    endfunction

    // called once per rising edge with the inputs the DUT sampled on that edge
    task automatic model_step();
        logic [7:0] pend;
        int         cand;
        e_jump = 1'b0; e_ret = 1'b0; e_target = '0;
        if (reset) begin
            model_clear();
            return;
        end
        if (m_push) begin
            stk_pc.push_back(pc_current);
            stk_ln.push_back(m_cand);
            e_jump   = 1'b1;
            e_target = PW'(32'h3C0 + 32'(m_cand) * 4);
            m_push   = 1'b0;
            m_wait   = 1;
        end else if (m_wait > 0) begin
            m_wait--;
        end else if (s_return_intr) begin
            if (stk_pc.size() > 0) begin
                e_ret    = 1'b1;
                e_target = stk_pc.pop_back();
                void'(stk_ln.pop_back());
                m_wait   = 1;
            end else begin
                e_udf = 1'b1;
            end
        end else begin
            pend = intr_active & ~stacked_mask();
            cand = -1;
            for (int i = 0; i < 8; i++) begin
                if (pend[i]) begin
                    cand = i;
                    break;
                end
            end
            if (cand >= 0 && (stk_ln.size() == 0 || cand < int'(stk_ln[$]))) begin
                if (stk_ln.size() == DEPTH) e_ovf = 1'b1;
                else begin
                    m_cand = 3'(cand);
                    m_push = 1'b1;
                end
            end
        end
        e_level = 3'(stk_ln.size());
        e_full  = (stk_ln.size() == DEPTH);
    endtask

    task automatic check_outputs();
        check_val("jump",     32'(s_intr_jump),     32'(e_jump));
        check_val("ret",      32'(s_intr_ret),      32'(e_ret));
        check_val("target",   32'(pc_target),       32'(e_target));
        check_val("level",    32'(intr_level),      32'(e_level));
        check_val("full",     32'(s_stack_full),    32'(e_full));
        check_val("overflow", 32'(s_err_overflow),  32'(e_ovf));
        check_val("underflw", 32'(s_err_underflow), 32'(e_udf));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1; intr_active = '0; s_return_intr = 1'b0;
        steps(2);
        reset = 1'b0;
    endtask

    task automatic reti();
        s_return_intr = 1'b1;
        step();
        s_return_intr = 1'b0;
        step();
    endtask

    initial begin
        model_clear();
        do_reset();
        check_val("rst_level", 32'(intr_level), 32'd0);

        // basic dispatch and return
        intr_active = 8'h08; pc_current = 10'h055;
        steps(2);
        check_val("t1_jump",   32'(s_intr_jump), 32'd1);
        check_val("t1_target", 32'(pc_target),   32'h3CC);
        check_val("t1_level",  32'(intr_level),  32'd1);
        step();
        intr_active = 8'h00;
        s_return_intr = 1'b1;
        step();
        s_return_intr = 1'b0;
        check_val("t2_ret",    32'(s_intr_ret), 32'd1);
        check_val("t2_target", 32'(pc_target),  32'h055);
        check_val("t2_level",  32'(intr_level), 32'd0);
        step();

        // nesting: higher priority preempts, lower priority waits
        intr_active = 8'h08; pc_current = 10'h100;
        steps(3);
        intr_active = 8'h0A; pc_current = 10'h120;
        steps(2);
        check_val("t3_jump",   32'(s_intr_jump), 32'd1);
        check_val("t3_target", 32'(pc_target),   32'h3C4);
        check_val("t3_level",  32'(intr_level),  32'd2);
        step();
        intr_active = 8'h00;
        reti();
        reti();
        intr_active = 8'h08; pc_current = 10'h140;
        steps(3);
        intr_active = 8'h28;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("t3_nojump", 32'(s_intr_jump), 32'd0);
        end
        intr_active = 8'h00;
        reti();

        // fill the stack, then an eligible request overflows
        intr_active = 8'h80; pc_current = 10'h200; steps(3);
        intr_active = 8'hC0; pc_current = 10'h210; steps(3);
        intr_active = 8'hE0; pc_current = 10'h220; steps(3);
        intr_active = 8'hF0; pc_current = 10'h230; steps(3);
        check_val("t4_full", 32'(s_stack_full), 32'd1);
        intr_active = 8'hF4;
        steps(2);
        check_val("t4_nojump", 32'(s_intr_jump),    32'd0);
        check_val("t4_ovf",    32'(s_err_overflow), 32'd1);
        check_val("t4_level",  32'(intr_level),     32'd4);
        intr_active = 8'h00;
        for (int i = 0; i < 4; i++) reti();

        // underflow, then return wins over a simultaneous request
        do_reset();
        s_return_intr = 1'b1;
        step();
        s_return_intr = 1'b0;
        check_val("t5_noret", 32'(s_intr_ret),      32'd0);
        check_val("t5_udf",   32'(s_err_underflow), 32'd1);
        intr_active = 8'h08; pc_current = 10'h0AA;
        steps(3);
        intr_active = 8'h0A; s_return_intr = 1'b1;
        step();
        s_return_intr = 1'b0; intr_active = 8'h00;
        check_val("t5_retwin", 32'(s_intr_ret), 32'd1);
        check_val("t5_rettgt", 32'(pc_target),  32'h0AA);
        steps(2);

        // reset during SAVE abandons the jump
        do_reset();
        intr_active = 8'h08; pc_current = 10'h077;
        step();
        reset = 1'b1;
        model_clear();
        #1;
        check_outputs();
        step();
        reset = 1'b0; intr_active = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("t6_nojump", 32'(s_intr_jump), 32'd0);
        end

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) intr_active = 8'($urandom);
            s_return_intr = ($urandom_range(0, 4) == 0);
            pc_current    = PW'($urandom);
            reset         = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
